prbs_burst_ctrl: RTL and testbench

Sequencer for the 31-bit PRBS generator (x^31 + x^28 + 1). It seeds the LFSR, gates its step enable to produce bursts of a programmed length separated by idle gaps, repeats for a programmed number of bursts, and injects single-bit errors on request. It sits between the pin-level command/config inputs and the LFSR datapath, which it drives via load/seed/enable/flip strobes.

---
 rtl/prbs_burst_ctrl.sv | 177 +++++++++++++++++
 tb/tb_prbs_burst_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_burst_ctrl.sv
// Burst sequencer for a 31-bit PRBS LFSR: seeds it, gates its step enable into
// bursts separated by idle gaps, and injects single-bit errors on request.
module prbs_burst_ctrl #(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             reseed,
  input  logic [30:0]      seed,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [CNT_W-1:0] burst_count,
  input  logic             inject_req,
  output logic             lfsr_load,
  output logic [30:0]      lfsr_seed,
  output logic             lfsr_en,
  output logic             err_flip,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] burst_idx
);

  // Handshake: start/stop/inject_req are level-sampled on every rising edge;
  // lfsr_load, lfsr_en, err_flip and done are single-cycle strobes to the datapath.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             reseed_q, reseed_d;
  logic [30:0]      seed_q, seed_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             pend_q, pend_d;

  logic             run_last;
  logic             gap_last;
  logic             flip_now;
  logic [CNT_W-1:0] idx_inc;

  // Note: this reset is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      reseed_q  <= 1'b0;
      seed_q    <= 31'd1;
      len_q     <= LEN_W'(1);
      gap_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      run_cnt_q <= '0;
      gap_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      reseed_q  <= reseed_d;
      seed_q    <= seed_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      run_cnt_q <= run_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reseed_d  = reseed_q;
    seed_d    = seed_q;
    len_d     = len_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    run_cnt_d = run_cnt_q;
    gap_cnt_d = gap_cnt_q;
    run_last  = (run_cnt_q == LEN_W'(1));
    gap_last  = (gap_cnt_q == GAP_W'(1));
    idx_inc   = idx_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          reseed_d = reseed;
          seed_d   = (seed == 31'd0) ? 31'd1 : seed;
          len_d    = (burst_len == '0) ? LEN_W'(1) : burst_len;
          gap_d    = gap_len;
          cnt_d    = burst_count;
          idx_d    = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_RUN;
          run_cnt_d = len_q;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          run_cnt_d = run_cnt_q - LEN_W'(1);
          if (run_last) begin
            idx_d = idx_inc;
            if (cnt_q != '0 && idx_inc == cnt_q) begin
              state_d = S_DONE;
            end else if (gap_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_q;
            end else if (reseed_q) begin
              state_d = S_LOAD;
            end else begin
              state_d   = S_RUN;
              run_cnt_d = len_q;
            end
          end
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          if (gap_last) begin
            if (reseed_q) begin
              state_d = S_LOAD;
            end else begin
              state_d   = S_RUN;
              run_cnt_d = len_q;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A request arriving in the same cycle that a flip is consumed arms a new flip.
  always_comb begin
    flip_now = (state_q == S_RUN) && pend_q;
    pend_d   = (pend_q && !flip_now) || (inject_req && (state_q != S_IDLE));
    if (state_d == S_IDLE) begin
      pend_d = 1'b0;
    end
  end

  assign lfsr_load = (state_q == S_LOAD);
  assign lfsr_seed = seed_q;
  assign lfsr_en   = (state_q == S_RUN);
  assign err_flip  = flip_now;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign burst_idx = idx_q;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Bench for prbs_burst_ctrl: directed config table, hand-written stop/inject/reset
// sequences, and randomized runs checked against a cycle-trace model.
module tb_prbs_burst_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        reseed;
  logic [30:0] seed;
  logic [15:0] burst_len;
  logic [7:0]  gap_len;
  logic [7:0]  burst_count;
  logic        inject_req;
  logic        lfsr_load;
  logic [30:0] lfsr_seed;
  logic        lfsr_en;
  logic        err_flip;
  logic        busy;
  logic        done;
  logic [7:0]  burst_idx;

  int n_vec = 0;
  int n_bad = 0;

  prbs_burst_ctrl #(.LEN_W(16), .GAP_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .reseed(reseed),
    .seed(seed), .burst_len(burst_len), .gap_len(gap_len),
    .burst_count(burst_count), .inject_req(inject_req),
    .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_en(lfsr_en),
    .err_flip(err_flip), .busy(busy), .done(done), .burst_idx(burst_idx)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len; int gap; int cnt; bit rs; int sd;
    int exp_loads; int exp_ens; int exp_done; int exp_idx; int exp_seed;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Driver: present config with start for one sampling edge; returns in cycle k+1.
  task automatic drive_start(input int len, input int gap, input int cnt,
                             input bit rs, input int sd);
    @(negedge clk);
    burst_len   = 16'(len);
    gap_len     = 8'(gap);
    burst_count = 8'(cnt);
    reseed      = rs;
    seed        = 31'(sd);
    inject_req  = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  // Observes one run; inject_req is raised during cycles inj_a and inj_b.
  task automatic run_cfg(input int len, input int gap, input int cnt, input bit rs,
                         input int sd, input int inj_a, input int inj_b,
                         output int loads, output int ens, output int flips,
                         output int first_flip, output int done_cyc,
                         output int idx_at_done, output int seed_seen,
                         output int busy_after);
    loads = 0; ens = 0; flips = 0; first_flip = -1; done_cyc = -1;
    idx_at_done = -1; seed_seen = -1; busy_after = -1;
    drive_start(len, gap, cnt, rs, sd);
    for (int c = 1; c <= 400; c++) begin
      if (lfsr_load) begin
        loads++;
        if (loads == 1) seed_seen = int'(lfsr_seed);
      end
      if (lfsr_en) ens++;
      if (err_flip) begin
        flips++;
        if (first_flip < 0) first_flip = c;
      end
      inject_req = (c == inj_a) || (c == inj_b);
      if (done) begin
        done_cyc    = c;
        idx_at_done = int'(burst_idx);
        @(negedge clk);
        busy_after  = int'(busy);
        break;
      end
      @(negedge clk);
    end
    inject_req = 1'b0;
  endtask

  // Scoreboard for random runs: per-cycle packed {load,en,flip,busy,done,idx[7:0]}
  logic [12:0] exp_q[$];
  bit          inj_q[$];

  function automatic logic [12:0] pack(input bit ld, input bit en, input bit fl,
                                       input bit bz, input bit dn, input int idx);
    return {ld, en, fl, bz, dn, 8'(idx)};
  endfunction

  // Reference: lay out the run as a list of phases, then overlay error flips.
  task automatic build_trace(input int len, input int gap, input int cnt, input bit rs);
    int  l_eff;
    bit  pend;
    bit  fl;
    l_eff = (len == 0) ? 1 : len;
    exp_q.delete();
    inj_q.delete();
    for (int b = 0; b < cnt; b++) begin
      if (b == 0 || rs) exp_q.push_back(pack(1, 0, 0, 1, 0, b));
      for (int i = 0; i < l_eff; i++) exp_q.push_back(pack(0, 1, 0, 1, 0, b));
      if (b < cnt - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(pack(0, 0, 0, 1, 0, b + 1));
    end
    exp_q.push_back(pack(0, 0, 0, 1, 1, cnt));
    exp_q.push_back(pack(0, 0, 0, 0, 0, cnt));
    for (int i = 0; i < exp_q.size(); i++)
      inj_q.push_back(exp_q[i][9] && !exp_q[i][8] && ($urandom_range(0, 7) == 0));
    pend = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      fl = exp_q[i][11] && pend;
      exp_q[i][10] = fl;
      pend = (pend && !fl) || inj_q[i];
    end
  endtask

  initial begin
    vec_t vecs[6];
    int loads, ens, flips, first_flip, done_cyc, idx_at_done, seed_seen, busy_after;
    int done_seen;
    int stop_ok;
    logic [12:0] act;
    logic [12:0] exp;

    vecs[0] = '{5, 0, 1, 1'b0, 1,          1, 5,  7,  1, 1};
    vecs[1] = '{4, 3, 3, 1'b1, 4660,       3, 12, 22, 3, 4660};
    vecs[2] = '{3, 0, 2, 1'b0, 77,         1, 6,  8,  2, 77};
    vecs[3] = '{0, 2, 2, 1'b1, 0,          2, 2,  7,  2, 1};
    vecs[4] = '{2, 1, 4, 1'b0, 2147483647, 1, 8,  13, 4, 2147483647};
    vecs[5] = '{7, 0, 3, 1'b1, 5,          3, 21, 25, 3, 5};

    rst_n = 1'b1; start = 1'b0; stop = 1'b0; reseed = 1'b0; seed = '0;
    burst_len = '0; gap_len = '0; burst_count = '0; inject_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_seed", int'(lfsr_seed), 1);
    check("reset_en_load_done", int'({lfsr_en, lfsr_load, done, err_flip}), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("idle_idx", int'(burst_idx), 0);

    // Directed config table
    for (int v = 0; v < 6; v++) begin
      run_cfg(vecs[v].len, vecs[v].gap, vecs[v].cnt, vecs[v].rs, vecs[v].sd, 0, 0,
              loads, ens, flips, first_flip, done_cyc, idx_at_done, seed_seen, busy_after);
      check($sformatf("v%0d_loads", v), loads, vecs[v].exp_loads);
      check($sformatf("v%0d_ens", v), ens, vecs[v].exp_ens);
      check($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].exp_done);
      check($sformatf("v%0d_idx", v), idx_at_done, vecs[v].exp_idx);
      check($sformatf("v%0d_seed", v), seed_seen, vecs[v].exp_seed);
      check($sformatf("v%0d_busy_after", v), busy_after, 0);
      check($sformatf("v%0d_flips", v), flips, 0);
    end

    // Stop in continuous mode after 100 enabled cycles; seed 0 becomes 1
    drive_start(40, 2, 0, 1'b1, 0);
    ens = 0; loads = 0; stop_ok = 0;
    for (int c = 1; c <= 500; c++) begin
      if (lfsr_load && loads++ == 0) check("stop_seed", int'(lfsr_seed), 1);
      if (lfsr_en) ens++;
      if (ens == 100) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_en_low", int'(lfsr_en), 0);
        check("stop_done", int'(done), 1);
        check("stop_idx", int'(burst_idx), 2);
        @(negedge clk);
        check("stop_busy_after", int'(busy), 0);
        stop_ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("stop_reached", stop_ok, 1);

    // Two injection requests during the gap merge into one flip
    run_cfg(4, 5, 2, 1'b0, 9, 6, 8,
            loads, ens, flips, first_flip, done_cyc, idx_at_done, seed_seen, busy_after);
    check("gap_inj_flips", flips, 1);
    check("gap_inj_cycle", first_flip, 11);
    check("gap_inj_done", done_cyc, 15);

    // Injection while idle is ignored
    @(negedge clk);
    inject_req = 1'b1;
    repeat (3) @(negedge clk);
    inject_req = 1'b0;
    run_cfg(3, 0, 1, 1'b0, 3, 0, 0,
            loads, ens, flips, first_flip, done_cyc, idx_at_done, seed_seen, busy_after);
    check("idle_inj_flips", flips, 0);

    // Reset in the middle of a burst
    drive_start(10, 0, 1, 1'b0, 85);
    repeat (3) @(negedge clk);
    check("pre_reset_en", int'(lfsr_en), 1);
    rst_n = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_strobes", int'({lfsr_en, lfsr_load, done, err_flip}), 0);
    check("rst_seed", int'(lfsr_seed), 1);
    check("rst_idx", int'(burst_idx), 0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      done_seen += int'(done);
    end
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      done_seen += int'(done);
    end
    check("rst_no_done", done_seen, 0);
    run_cfg(5, 0, 1, 1'b0, 1, 0, 0,
            loads, ens, flips, first_flip, done_cyc, idx_at_done, seed_seen, busy_after);
    check("post_rst_done", done_cyc, 7);
    check("post_rst_ens", ens, 5);

    // Randomized runs against the trace model
    for (int r = 0; r < 12; r++) begin
      int len, gap, cnt, sd;
      bit rs;
      len = $urandom_range(0, 6);
      gap = $urandom_range(0, 3);
      cnt = $urandom_range(1, 4);
      rs  = 1'($urandom_range(0, 1));
      sd  = int'($urandom_range(0, 1000));
      build_trace(len, gap, cnt, rs);
      drive_start(len, gap, cnt, rs, sd);
      for (int i = 0; i < exp_q.size(); i++) begin
        act = {lfsr_load, lfsr_en, err_flip, busy, done, burst_idx};
        exp = exp_q[i];
        n_vec++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL rand%0d_cyc%0d: got {ld,en,fl,bz,dn,idx}=%b, expected %b",
                   r, i + 1, act, exp);
        end
        inject_req = inj_q[i];
        @(negedge clk);
      end
      inject_req = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
